// File: rtl/ysyx_25040101_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25040101_pkg
// Shared types and constants for the ysyx_25040101 memory arbiter:
//   state_e  - arbiter FSM states (IDLE, REQ, RESP, DONE)
//   owner_e  - which master owns the current transaction (IFU=0, LSU=1)
//   req_t    - buffered request payload forwarded to the memory slave
//   ADDR_W / DATA_W / STRB_W - bus widths
// ---------------------------------------------------------------------------
package ysyx_25040101_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // The encoding doubles as the bit index into the arbiter grant vector.
  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wen;
  } req_t;

  // Fetches are read-only: the store fields are forced to zero so the slave
  // never sees stray strobes from the fetch path.
  function automatic req_t make_ifu_req(input logic [ADDR_W-1:0] addr);
    req_t r;
    r.addr  = addr;
    r.wdata = '0;
    r.wstrb = '0;
    r.wen   = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_25040101_rr_arb2.sv
// ---------------------------------------------------------------------------
// ysyx_25040101_rr_arb2
// Combinational 2-way round-robin picker.
//   i_req[0]/i_req[1] - IFU / LSU request bits
//   i_last_grant      - owner granted by the previous completed transaction
//   o_grant[1:0]      - one-hot grant (bit index = owner_e encoding)
// A lone requester always wins; under contention the master that was not
// granted last wins.
// ---------------------------------------------------------------------------
module ysyx_25040101_rr_arb2
  import ysyx_25040101_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_e     i_last_grant,
  output logic [1:0] o_grant
);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    o_grant = 2'b00;
    unique case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_last_grant == OWNER_LSU) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_25040101_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_25040101_mem_arbiter
// Shares one memory slave port between the IFU (read-only) and the LSU
// (read/write). One transaction at a time; request and response are buffered.
//
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_ifu_req_* / o_ifu_req_ready       IFU request handshake + address
//   o_ifu_resp_* / i_ifu_resp_ready     IFU response handshake, data, error
//   i_lsu_req_* / o_lsu_req_ready       LSU request handshake + payload
//   o_lsu_resp_* / i_lsu_resp_ready     LSU response handshake, data, error
//   o_s_req_* / i_s_req_ready           request to the memory slave
//   i_s_resp_* / o_s_resp_ready         response from the memory slave
//   o_busy                              arbiter not idle
//
// TIMEOUT_CYCLES (>= 2) bounds the cycles spent in REQ+RESP; on expiry the
// owner receives rdata=0, err=1.
// ---------------------------------------------------------------------------
module ysyx_25040101_mem_arbiter
  import ysyx_25040101_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,

  input  logic              i_ifu_req_valid,
  output logic              o_ifu_req_ready,
  input  logic [ADDR_W-1:0] i_ifu_req_addr,
  output logic              o_ifu_resp_valid,
  input  logic              i_ifu_resp_ready,
  output logic [DATA_W-1:0] o_ifu_resp_rdata,
  output logic              o_ifu_resp_err,

  input  logic              i_lsu_req_valid,
  output logic              o_lsu_req_ready,
  input  logic [ADDR_W-1:0] i_lsu_req_addr,
  input  logic [DATA_W-1:0] i_lsu_req_wdata,
  input  logic [STRB_W-1:0] i_lsu_req_wstrb,
  input  logic              i_lsu_req_wen,
  output logic              o_lsu_resp_valid,
  input  logic              i_lsu_resp_ready,
  output logic [DATA_W-1:0] o_lsu_resp_rdata,
  output logic              o_lsu_resp_err,

  output logic              o_s_req_valid,
  input  logic              i_s_req_ready,
  output logic [ADDR_W-1:0] o_s_req_addr,
  output logic [DATA_W-1:0] o_s_req_wdata,
  output logic [STRB_W-1:0] o_s_req_wstrb,
  output logic              o_s_req_wen,
  input  logic              i_s_resp_valid,
  output logic              o_s_resp_ready,
  input  logic [DATA_W-1:0] i_s_resp_rdata,
  input  logic              i_s_resp_err,

  output logic              o_busy
);

  // Timer only needs to reach TIMEOUT_CYCLES-1 before the FSM leaves.
  localparam int              TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  owner_e            r_owner;
  owner_e            r_last_grant;
  req_t              r_req;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [TW-1:0]     r_timer;

  logic [1:0]        w_grant;
  logic              w_grant_any;
  logic              w_timeout;
  logic              w_done;
  logic              w_owner_ready;
  logic              w_resp_hs;

  ysyx_25040101_rr_arb2 u_rr_arb2 (
    .i_req        ({i_lsu_req_valid, i_ifu_req_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_grant_any   = |w_grant;
  assign w_timeout     = (r_timer == TIMER_LAST);
  assign w_done        = (r_state == ST_DONE);
  assign w_owner_ready = (r_owner == OWNER_LSU) ? i_lsu_resp_ready : i_ifu_resp_ready;
  assign w_resp_hs     = w_done && w_owner_ready;

  // Next-state logic. A successful handshake is tested before the timeout so
  // success wins when both coincide.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_grant_any)    w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (i_s_req_ready)         w_state_nxt = ST_RESP;
        else if (w_timeout)        w_state_nxt = ST_DONE;
      end
      ST_RESP: begin
        if (i_s_resp_valid)        w_state_nxt = ST_DONE;
        else if (w_timeout)        w_state_nxt = ST_DONE;
      end
      ST_DONE: if (w_resp_hs)      w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: the request/response buffers are plain registers, not a memory, so
  // they are reset; this keeps the slave payload and response data outputs at
  // zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner      <= OWNER_IFU;
      r_last_grant <= OWNER_LSU;
      r_req        <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_timer      <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_timer <= '0;
            if (w_grant[OWNER_LSU]) begin
              r_owner      <= OWNER_LSU;
              r_req.addr   <= i_lsu_req_addr;
              r_req.wdata  <= i_lsu_req_wdata;
              r_req.wstrb  <= i_lsu_req_wstrb;
              r_req.wen    <= i_lsu_req_wen;
            end else begin
              r_owner <= OWNER_IFU;
              r_req   <= make_ifu_req(i_ifu_req_addr);
            end
          end
        end
        ST_REQ: begin
          r_timer <= r_timer + 1'b1;
          if (!i_s_req_ready && w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        ST_RESP: begin
          r_timer <= r_timer + 1'b1;
          if (i_s_resp_valid) begin
            r_rdata <= i_s_resp_rdata;
            r_err   <= i_s_resp_err;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (w_resp_hs) r_last_grant <= r_owner;
        end
        default: ;
      endcase
    end
  end

  // Master-side outputs: only the winner/owner ever sees ready/valid/data.
  assign o_ifu_req_ready  = (r_state == ST_IDLE) && w_grant[OWNER_IFU];
  assign o_lsu_req_ready  = (r_state == ST_IDLE) && w_grant[OWNER_LSU];

  assign o_ifu_resp_valid = w_done && (r_owner == OWNER_IFU);
  assign o_lsu_resp_valid = w_done && (r_owner == OWNER_LSU);
  assign o_ifu_resp_rdata = o_ifu_resp_valid ? r_rdata : '0;
  assign o_lsu_resp_rdata = o_lsu_resp_valid ? r_rdata : '0;
  assign o_ifu_resp_err   = o_ifu_resp_valid && r_err;
  assign o_lsu_resp_err   = o_lsu_resp_valid && r_err;

  // Slave-side outputs. s_resp_ready stays high outside DONE so stale
  // responses from abandoned transactions are drained and dropped.
  assign o_s_req_valid    = (r_state == ST_REQ);
  assign o_s_req_addr     = r_req.addr;
  assign o_s_req_wdata    = r_req.wdata;
  assign o_s_req_wstrb    = r_req.wstrb;
  assign o_s_req_wen      = r_req.wen;
  assign o_s_resp_ready   = (r_state != ST_DONE);

  assign o_busy           = (r_state != ST_IDLE);

endmodule
